// File: rtl/relu_pkg.sv
// Shared constants for the relu job controller: FSM encoding, default widths
// and the relu datapath latency that sizes the in-flight valid pipe.
package relu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int NUM_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF = 16;
  localparam int RELU_LAT      = 2;

  // Number of words currently inside the relu datapath (0..RELU_LAT).
  function automatic logic [1:0] pipe_count(input logic [RELU_LAT-1:0] v);
    logic [1:0] n;
    n = '0;
    for (int i = 0; i < RELU_LAT; i++) n = n + {1'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/relu.sv
// Two-cycle rectifier datapath: register the input, then register either the
// word itself (bypass or non-negative) or zero. No stall, no reset.
module relu
  import relu_pkg::*;
#(
  parameter int NUM_WIDTH = NUM_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 bypass_i,
  input  logic [NUM_WIDTH-1:0] data_i,
  output logic [NUM_WIDTH-1:0] data_o
);

  logic [NUM_WIDTH-1:0] in_q;
  logic [NUM_WIDTH-1:0] out_q;

  always_ff @(posedge clk) begin
    in_q  <= data_i;
    out_q <= (bypass_i || !in_q[NUM_WIDTH-1]) ? in_q : '0;
  end

  assign data_o = out_q;

endmodule

// File: rtl/relu_fifo.sv
// Synchronous FIFO holding {last, data} words between the relu datapath and
// the downstream consumer. DEPTH must be a power of two.
module relu_fifo
  import relu_pkg::*;
#(
  parameter int WIDTH = NUM_WIDTH_DEF + 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;

  // The controller's credit check must make this impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o));

endmodule

// File: rtl/relu_ctrl.sv
// Job controller streaming count words through relu into a credit-protected
// output FIFO. Define RELU_CTRL_STATS_EN to count words zeroed per job.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a job descriptor, cfg_ready high
// ST_RUN   | accepting upstream words while remaining != 0
// ST_DRAIN | all words accepted, waiting for relu and FIFO to empty
// ST_DONE  | one-cycle completion pulse
module relu_ctrl
  import relu_pkg::*;
#(
  parameter int NUM_WIDTH  = NUM_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 cfg_bypass,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [NUM_WIDTH-1:0] up_data,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [NUM_WIDTH-1:0] dn_data,
  output logic                 dn_last,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] stat_zeroed
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OCC_W:0] DEPTH_C = (OCC_W+1)'(FIFO_DEPTH);

  logic [1:0]           state_q, state_d;
  logic                 bypass_q, bypass_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                 last_popped_q, last_popped_d;
  logic [RELU_LAT-1:0]  vp_q, lp_q;

  logic                 accept, xfer, push, pop;
  logic                 fifo_empty, fifo_full, head_last;
  logic [NUM_WIDTH-1:0] relu_out, head_data;
  logic [OCC_W-1:0]     occ;
  logic [1:0]           inflight;
  logic [OCC_W:0]       credit_used;

  assign accept      = (state_q == ST_IDLE) && cfg_valid;
  assign inflight    = pipe_count(vp_q);
  assign credit_used = {1'b0, occ} + {{(OCC_W-1){1'b0}}, inflight};
  assign up_ready    = (state_q == ST_RUN) && (remaining_q != '0) &&
                       (credit_used < DEPTH_C) && !fifo_full;
  assign xfer        = up_valid && up_ready;
  assign push        = vp_q[RELU_LAT-1];
  assign dn_valid    = !fifo_empty;
  assign pop         = dn_valid && dn_ready;
  // FIFO storage is not reset, so mask the head while empty.
  assign dn_data     = dn_valid ? head_data : '0;
  assign dn_last     = dn_valid && head_last;
  assign cfg_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

  always_comb begin
    state_d       = state_q;
    bypass_d      = bypass_q;
    remaining_d   = remaining_q;
    last_popped_d = last_popped_q || (pop && head_last);
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          bypass_d      = cfg_bypass;
          remaining_d   = cfg_count;
          last_popped_d = 1'b0;
          state_d       = (cfg_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer) remaining_d = remaining_q - 1'b1;
        if (remaining_d == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((vp_q == '0) && fifo_empty && last_popped_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bypass_q      <= 1'b0;
      remaining_q   <= '0;
      last_popped_q <= 1'b0;
      vp_q          <= '0;
      lp_q          <= '0;
    end else begin
      state_q       <= state_d;
      bypass_q      <= bypass_d;
      remaining_q   <= remaining_d;
      last_popped_q <= last_popped_d;
      vp_q          <= {vp_q[RELU_LAT-2:0], xfer};
      lp_q          <= {lp_q[RELU_LAT-2:0], xfer && (remaining_q == CNT_WIDTH'(1))};
    end
  end

  relu #(.NUM_WIDTH(NUM_WIDTH)) u_relu (
    .clk      (clk),
    .bypass_i (bypass_q),
    .data_i   (up_data),
    .data_o   (relu_out)
  );

  relu_fifo #(.WIDTH(NUM_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({lp_q[RELU_LAT-1], relu_out}),
    .pop_i   (pop),
    .data_o  ({head_last, head_data}),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (occ)
  );

`ifdef RELU_CTRL_STATS_EN
  logic [RELU_LAT-1:0]  sp_q;
  logic [CNT_WIDTH-1:0] stat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q   <= '0;
      stat_q <= '0;
    end else begin
      sp_q <= {sp_q[RELU_LAT-2:0], up_data[NUM_WIDTH-1]};
      if (accept)
        stat_q <= '0;
      else if (push && !bypass_q && sp_q[RELU_LAT-1] && (stat_q != '1))
        stat_q <= stat_q + 1'b1;
    end
  end

  assign stat_zeroed = stat_q;
`else
  assign stat_zeroed = '0;
`endif

endmodule

// File: tb/tb_relu_ctrl.sv
// Scoreboard bench for relu_ctrl: expected words are queued as upstream
// transfers happen and compared as the downstream side pops them.
module tb_relu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready, cfg_bypass;
  logic [15:0] cfg_count;
  logic        up_valid, up_ready;
  logic [15:0] up_data;
  logic        dn_valid, dn_ready, dn_last;
  logic [15:0] dn_data;
  logic        busy, done;
  logic [15:0] stat_zeroed;

  relu_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_bypass  (cfg_bypass),
    .cfg_count   (cfg_count),
    .up_valid    (up_valid),
    .up_ready    (up_ready),
    .up_data     (up_data),
    .dn_valid    (dn_valid),
    .dn_ready    (dn_ready),
    .dn_data     (dn_data),
    .dn_last     (dn_last),
    .busy        (busy),
    .done        (done),
    .stat_zeroed (stat_zeroed)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [16:0] exp_q [$];
  logic [15:0] stim [$];
  logic [16:0] e;
  logic        cur_bypass;
  int          cur_count;
  int          exp_stat;
  int          cyc = 0;
  int          xfer_total = 0, pop_total = 0, max_out = 0;
  int          xfer_job = 0, pop_job = 0, done_cnt = 0;
  int          first_xfer_cyc, last_xfer_cyc, first_pop_cyc, last_pop_cyc;
  logic        saw_bp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic byp, input logic [15:0] d);
    return (byp || !d[15]) ? d : 16'h0000;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (xfer_total - pop_total > max_out) max_out = xfer_total - pop_total;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (busy && up_valid && !up_ready && !dn_ready) saw_bp = 1'b1;
      if (dn_valid && dn_ready) begin
        pop_total++;
        pop_job++;
        last_pop_cyc = cyc;
        if (pop_job == 1) first_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_out", {31'b0, dn_valid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("dn_data", {16'b0, dn_data}, {16'b0, e[15:0]});
          check("dn_last", {31'b0, dn_last}, {31'b0, e[16]});
        end
      end
    end
  end

  task automatic start_job(input logic byp, input int cnt);
    int t = 0;
    @(negedge clk);
    while (!cfg_ready && t < 50) begin @(negedge clk); t++; end
    check("cfg_ready", {31'b0, cfg_ready}, 32'h1);
    cur_bypass = byp;
    cur_count  = cnt;
    exp_stat   = 0;
    xfer_job   = 0;
    pop_job    = 0;
    cfg_valid  = 1'b1;
    cfg_bypass = byp;
    cfg_count  = 16'(cnt);
    @(posedge clk); #1;
    cfg_valid  = 1'b0;
  endtask

  task automatic stream(input int n_send);
    for (int i = 0; i < n_send; i++) begin
      int t = 0;
      up_valid = 1'b1;
      up_data  = stim[i];
      @(negedge clk);
      while (!up_ready && t < 200) begin @(negedge clk); t++; end
      if (!up_ready) begin
        check("up_ready_timeout", {31'b0, up_ready}, 32'h1);
        break;
      end
      exp_q.push_back({(i == cur_count - 1), model(cur_bypass, stim[i])});
      if (!cur_bypass && stim[i][15]) exp_stat++;
      if (xfer_job == 0) first_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
      xfer_job++;
      xfer_total++;
      @(posedge clk); #1;
    end
    up_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int waited);
    int t = 0;
    int base = done_cnt;
    @(negedge clk);
    while (!done && t < 1000) begin @(negedge clk); t++; end
    waited = t;
    check({tag, "_done"}, {31'b0, done}, 32'h1);
    check({tag, "_q_empty"}, exp_q.size(), 32'h0);
    @(negedge clk);
    check({tag, "_done_width"}, {31'b0, done}, 32'h0);
    check({tag, "_idle"}, {31'b0, busy}, 32'h0);
    check({tag, "_done_count"}, done_cnt - base, 32'h1);
`ifdef RELU_CTRL_STATS_EN
    check({tag, "_stat"}, {16'b0, stat_zeroed}, exp_stat);
`else
    check({tag, "_stat"}, {16'b0, stat_zeroed}, 32'h0);
`endif
  endtask

  initial begin
    int w;
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_bypass = 1'b0; cfg_count = '0;
    up_valid = 1'b0; up_data = '0; dn_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cfg_ready", {31'b0, cfg_ready}, 32'h1);
    check("rst_up_ready", {31'b0, up_ready}, 32'h0);
    check("rst_dn_valid", {31'b0, dn_valid}, 32'h0);
    check("rst_dn_data", {16'b0, dn_data}, 32'h0);
    check("rst_dn_last", {31'b0, dn_last}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_stat", {16'b0, stat_zeroed}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // rectify job
    stim = '{16'h0005, 16'hFFFF, 16'h8000, 16'h7FFF};
    start_job(1'b0, 4);
    stream(4);
    wait_done("rect", w);
    check("rect_pops", pop_job, 32'd4);

    // bypass job
    stim = '{16'hFFFF, 16'h8001, 16'h0002};
    start_job(1'b1, 3);
    stream(3);
    wait_done("byp", w);
    check("byp_pops", pop_job, 32'd3);

    // zero-length job
    start_job(1'b0, 0);
    check("cnt0_up_ready", {31'b0, up_ready}, 32'h0);
    wait_done("cnt0", w);
    check("cnt0_latency", w, 32'd0);
    check("cnt0_pops", pop_job, 32'd0);

    // backpressure mid-stream
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(16'($urandom));
    max_out = 0;
    saw_bp  = 1'b0;
    start_job(1'b0, 16);
    fork
      stream(16);
      begin : stall_blk
        int t = 0;
        while (pop_job < 4 && t < 200) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        dn_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        dn_ready = 1'b1;
      end
    join
    wait_done("stall", w);
    check("stall_pops", pop_job, 32'd16);
    check("stall_max_outstanding", max_out, 32'd4);
    check("stall_up_ready_dropped", {31'b0, saw_bp}, 32'h1);

    // full throughput
    stim.delete();
    for (int i = 0; i < 64; i++) stim.push_back(16'($urandom));
    start_job(1'b0, 64);
    stream(64);
    wait_done("tput", w);
    check("tput_pops", pop_job, 32'd64);
    check("tput_in_span", last_xfer_cyc - first_xfer_cyc, 32'd63);
    check("tput_fill", first_pop_cyc - first_xfer_cyc, 32'd3);
    check("tput_out_span", last_pop_cyc - first_pop_cyc, 32'd63);

    // reset mid-job, then a clean follow-up job
    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(16'h8000 | 16'(i));
    start_job(1'b0, 10);
    stream(5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    pop_total = xfer_total;
    @(negedge clk);
    check("mid_rst_dn_valid", {31'b0, dn_valid}, 32'h0);
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    check("mid_rst_cfg_ready", {31'b0, cfg_ready}, 32'h1);
    check("mid_rst_done", {31'b0, done}, 32'h0);
    check("mid_rst_stat", {16'b0, stat_zeroed}, 32'h0);
    stim = '{16'h1234, 16'h8765};
    start_job(1'b0, 2);
    stream(2);
    wait_done("post_rst", w);
    check("post_rst_pops", pop_job, 32'd2);
    repeat (5) @(negedge clk);
    check("post_rst_quiet", {31'b0, dn_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
